// File: rtl/board_pkg.sv
// Board-wide constants and the shared button FSM encoding.
// All timing limits derive from the 100 MHz board clock.
package board_pkg;

    localparam int unsigned CLK_FREQ_HZ         = 100_000_000;
    localparam logic [31:0] ONE_SEC_LIMIT       = 32'(CLK_FREQ_HZ - 1);
    localparam logic [31:0] DEBOUNCE_10MS_LIMIT = 32'(CLK_FREQ_HZ / 100 - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } btn_state_e;

endpackage

// File: rtl/sync_bit.sv
// Single-bit synchronizer: a STAGES-deep flop chain with asynchronous reset to 0.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: synchronizer, counter debouncer, press/release strobes
// and a one-shot long-press detector. All outputs come straight from flops.
module btn_debounce
    import board_pkg::*;
#(
    parameter int unsigned            COUNT_WIDTH    = 32,
    parameter int unsigned            SYNC_STAGES    = 2,
    parameter logic [COUNT_WIDTH-1:0] DEBOUNCE_LIMIT = COUNT_WIDTH'(DEBOUNCE_10MS_LIMIT),
    parameter logic [COUNT_WIDTH-1:0] HOLD_LIMIT     = COUNT_WIDTH'(ONE_SEC_LIMIT)
) (
    input  logic clk,
    input  logic a_reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_hold,
    output logic btn_long
);

    logic                   sync_q;
    btn_state_e             state_q, state_d;
    logic [COUNT_WIDTH-1:0] db_cnt_q, db_cnt_d;
    logic [COUNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   hold_q, hold_d;
    logic                   long_q, long_d;
    logic                   accept;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i(clk),
        .rst_i(a_reset),
        .d_i  (btn_in),
        .q_o  (sync_q)
    );

    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        hold_d     = 1'b0;
        long_d     = long_q;
        accept     = (sync_q != level_q) && (db_cnt_q == DEBOUNCE_LIMIT);

        if (sync_q == level_q) begin
            db_cnt_d = '0;
        end else if (accept) begin
            db_cnt_d  = '0;
            level_d   = sync_q;
            press_d   = sync_q;
            release_d = !sync_q;
        end else begin
            db_cnt_d = db_cnt_q + COUNT_WIDTH'(1);
        end

        // A release accepted on the hold-compare edge suppresses the hold.
        if (!level_q || release_d) begin
            hold_cnt_d = '0;
            long_d     = 1'b0;
        end else if (!long_q) begin
            if (hold_cnt_q == HOLD_LIMIT) begin
                hold_d = 1'b1;
                long_d = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + COUNT_WIDTH'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (accept)      state_d = StPressed;
                else if (sync_q) state_d = StPressWait;
            end
            StPressWait: begin
                if (accept)       state_d = StPressed;
                else if (!sync_q) state_d = StIdle;
            end
            StPressed: begin
                if (accept)       state_d = StIdle;
                else if (!sync_q) state_d = StReleaseWait;
            end
            StReleaseWait: begin
                if (accept)      state_d = StIdle;
                else if (sync_q) state_d = StPressed;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            state_q    <= StIdle;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            hold_q     <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            hold_q     <= hold_d;
            long_q     <= long_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_hold    = hold_q;
    assign btn_long    = long_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with small limits and a run-length reference model.
module tb_btn_debounce;

    localparam int SYNC = 2;
    localparam int DB   = 3;
    localparam int HOLD = 9;

    logic clk, a_reset, btn_in;
    logic btn_level, btn_press, btn_release, btn_hold, btn_long;
    int   checks, failures;

    btn_debounce #(
        .COUNT_WIDTH   (32),
        .SYNC_STAGES   (SYNC),
        .DEBOUNCE_LIMIT(32'(DB)),
        .HOLD_LIMIT    (32'(HOLD))
    ) dut (
        .clk        (clk),
        .a_reset    (a_reset),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_hold   (btn_hold),
        .btn_long   (btn_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: input seen SYNC edges late; accept after DB+1 consecutive
    // differing edges; hold fires HOLD+1 edges after the press unless released.
    logic m_level, m_press, m_release, m_hold, m_long;
    int   m_run, m_since;
    bit   hist[$];

    always @(posedge clk or posedge a_reset) begin
        bit s, acc;
        if (a_reset) begin
            {m_level, m_press, m_release, m_hold, m_long} = '0;
            m_run = 0;
            m_since = 0;
            hist = {};
            for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
        end else begin
            s = hist[0];
            void'(hist.pop_front());
            hist.push_back(btn_in);
            {m_press, m_release, m_hold} = '0;
            acc = 1'b0;
            if (s != m_level) begin
                m_run++;
                if (m_run == DB + 1) begin
                    acc = 1'b1;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            if (m_level) m_since++;
            if (acc) begin
                if (s) begin
                    m_press = 1'b1;
                    m_since = 0;
                end else begin
                    m_release = 1'b1;
                    m_long = 1'b0;
                end
                m_level = s;
            end else if (m_level && !m_long && m_since == HOLD + 1) begin
                m_hold = 1'b1;
                m_long = 1'b1;
            end
        end
    end

    wire [4:0] dut_vec = {btn_level, btn_press, btn_release, btn_hold, btn_long};
    wire [4:0] m_vec   = {m_level, m_press, m_release, m_hold, m_long};

    task automatic test_reset();
        a_reset = 1'b1;
        btn_in  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec !== 5'b0) begin
            failures++;
            $display("FAIL reset_values got=%b want=00000", dut_vec);
        end
        a_reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== m_vec) begin
                failures++;
                $display("FAIL reset_idle got=%b want=%b", dut_vec, m_vec);
            end
        end
    endtask

    task automatic test_clean_press();
        btn_in = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== m_vec) begin
                failures++;
                $display("FAIL clean_model t=%0d got=%b want=%b", t, dut_vec, m_vec);
            end
            if (t <= 9) begin
                checks++;
                if (btn_press !== (t == 6) || btn_level !== (t >= 6) || btn_release || btn_hold)
                begin
                    failures++;
                    $display("FAIL clean_press t=%0d got=%b press_at=6", t, dut_vec);
                end
            end
            if (t == 9) btn_in = 1'b0;
        end
    endtask

    task automatic test_bounce();
        btn_in = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== m_vec) begin
                failures++;
                $display("FAIL bounce_model t=%0d got=%b want=%b", t, dut_vec, m_vec);
            end
            if (t <= 20) begin
                checks++;
                if (btn_press !== (t == 14) || btn_level !== (t >= 14) || btn_release) begin
                    failures++;
                    $display("FAIL bounce_press t=%0d got=%b press_at=14", t, dut_vec);
                end
            end
            if (t < 8)       btn_in = ((t / 2) % 2) == 0;
            else if (t < 20) btn_in = 1'b1;
            else             btn_in = 1'b0;
        end
    endtask

    task automatic test_long_press();
        int holds = 0;
        btn_in = 1'b1;
        for (int t = 1; t <= 50; t++) begin
            @(negedge clk);
            if (btn_hold) holds++;
            checks++;
            if (dut_vec !== m_vec) begin
                failures++;
                $display("FAIL long_model t=%0d got=%b want=%b", t, dut_vec, m_vec);
            end
            checks++;
            if (btn_hold !== (t == 16) || btn_long !== (t >= 16 && t < 36) ||
                btn_release !== (t == 36) || btn_press !== (t == 6)) begin
                failures++;
                $display("FAIL long_press t=%0d got=%b hold_at=16 release_at=36", t, dut_vec);
            end
            if (t == 30) btn_in = 1'b0;
        end
        checks++;
        if (holds !== 1) begin
            failures++;
            $display("FAIL long_hold_count got=%0d want=1", holds);
        end
    endtask

    task automatic test_short_press();
        btn_in = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== m_vec) begin
                failures++;
                $display("FAIL short_model t=%0d got=%b want=%b", t, dut_vec, m_vec);
            end
            checks++;
            if (btn_press !== (t == 6) || btn_release !== (t == 16) || btn_hold || btn_long) begin
                failures++;
                $display("FAIL short_press t=%0d got=%b press_at=6 release_at=16", t, dut_vec);
            end
            if (t == 10) btn_in = 1'b0;
        end
    endtask

    // A one-cycle dip enters release-wait and returns, then the real release lands on
    // the hold-compare edge.
    task automatic test_collision();
        btn_in = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== m_vec) begin
                failures++;
                $display("FAIL collide_model t=%0d got=%b want=%b", t, dut_vec, m_vec);
            end
            if (t == 16) begin
                checks++;
                if (dut_vec !== 5'b00100) begin
                    failures++;
                    $display("FAIL collide_edge got=%b want=00100", dut_vec);
                end
            end
            if (t > 16) begin
                checks++;
                if (btn_hold || btn_long || btn_level) begin
                    failures++;
                    $display("FAIL collide_after t=%0d got=%b want=00000", t, dut_vec);
                end
            end
            if (t == 7)  btn_in = 1'b0;
            if (t == 8)  btn_in = 1'b1;
            if (t == 10) btn_in = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        // Reset while in press-wait.
        btn_in = 1'b1;
        repeat (3) @(negedge clk);
        #2 a_reset = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 5'b0) begin
            failures++;
            $display("FAIL reset_presswait got=%b want=00000", dut_vec);
        end
        @(negedge clk);
        a_reset = 1'b0;
        for (int t = 1; t <= 18; t++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== m_vec || btn_press !== (t == 6)) begin
                failures++;
                $display("FAIL reset_redebounce t=%0d got=%b press_at=6", t, dut_vec);
            end
        end
        // Reset while long is active: outputs drop at once, not at the next edge.
        #2 a_reset = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 5'b0) begin
            failures++;
            $display("FAIL reset_async got=%b want=00000", dut_vec);
        end
        @(negedge clk);
        checks++;
        if (dut_vec !== 5'b0) begin
            failures++;
            $display("FAIL reset_held got=%b want=00000", dut_vec);
        end
        a_reset = 1'b0;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== m_vec || btn_press !== (t == 6)) begin
                failures++;
                $display("FAIL reset_held_btn t=%0d got=%b want=%b", t, dut_vec, m_vec);
            end
            if (t == 8) btn_in = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 60; seg++) begin
            btn_in = 1'($urandom_range(0, 1));
            for (int c = 0; c < int'($urandom_range(1, 16)); c++) begin
                @(negedge clk);
                checks++;
                if (dut_vec !== m_vec) begin
                    failures++;
                    $display("FAIL random_model seg=%0d got=%b want=%b", seg, dut_vec, m_vec);
                end
                checks++;
                if ($countones({btn_press, btn_release, btn_hold}) > 1) begin
                    failures++;
                    $display("FAIL random_strobes got=%b want=at_most_one", dut_vec);
                end
            end
        end
        btn_in = 1'b0;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== m_vec) begin
                failures++;
                $display("FAIL random_settle got=%b want=%b", dut_vec, m_vec);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        a_reset  = 1'b1;
        btn_in   = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_short_press();
        test_collision();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
